// File: rtl/scr1_trace_sched_pkg.sv
// Shared types for the SCR1 trace scheduler: record layout,
// FSM states and small arithmetic helpers.
package scr1_trace_sched_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        REC_PC   = 2'd0,
        REC_MPRF = 2'd1,
        REC_CSR  = 2'd2,
        REC_DROP = 2'd3
    } rec_type_e;

    typedef struct packed {
        rec_type_e   rtype;
        logic [4:0]  tag;
        logic [31:0] ts;
        logic [31:0] data;
    } rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [1:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/scr1_trace_fifo.sv
// Synchronous record FIFO; head entry is read straight from the
// storage registers so it is stable while the consumer stalls.
module scr1_trace_fifo
    import scr1_trace_sched_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  rec_t din,
    input  logic pop,
    output rec_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/scr1_trace_sched.sv
// Trace capture scheduler: three event sources with one-deep holds,
// round-robin arbitration into a record FIFO, overflow reporting.
module scr1_trace_sched
    import scr1_trace_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_start,
    input  logic        ctrl_stop,
    input  logic        update_pc_en,
    input  logic [31:0] update_pc,
    input  logic        mprf_wr_en,
    input  logic [4:0]  mprf_wr_addr,
    input  logic [31:0] mprf_wr_data,
    input  logic        csr_chg,
    input  logic [2:0]  csr_sel,
    input  logic [31:0] csr_data,
    output logic        rec_vld,
    input  logic        rec_rdy,
    output logic [1:0]  rec_type,
    output logic [4:0]  rec_tag,
    output logic [31:0] rec_ts,
    output logic [31:0] rec_data,
    output logic        busy,
    output logic [15:0] ovf_cnt
);
    state_e      state_q;
    state_e      state_d;
    logic [31:0] ts_q;
    rec_t        hold [3];
    rec_t        ev_rec [3];
    logic [2:0]  hold_vld;
    logic [2:0]  ev;
    logic [2:0]  grant;
    logic [2:0]  drop;
    logic [1:0]  rr_q;
    logic [1:0]  rr_d;
    logic [1:0]  n_drop;
    logic        drop_pend;
    logic [15:0] drop_cnt;
    logic        drop_gnt;
    logic        start;
    logic        run;
    logic        push;
    logic        full;
    logic        empty;
    rec_t        push_rec;
    rec_t        head;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ctrl_start && !ctrl_stop) state_d = ST_RUN;
            ST_RUN:   if (ctrl_stop) state_d = ST_DRAIN;
            ST_DRAIN: if (hold_vld == '0 && !drop_pend && empty)
                          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign start = (state_q == ST_IDLE) && (state_d == ST_RUN);
    assign run   = (state_q == ST_RUN);
    assign busy  = (state_q != ST_IDLE);

    assign ev[0] = run & update_pc_en;
    assign ev[1] = run & mprf_wr_en & (|mprf_wr_addr);
    assign ev[2] = run & csr_chg;

    always_comb begin
        ev_rec[0] = '{rtype: REC_PC, tag: 5'd0,
                      ts: ts_q, data: update_pc};
        ev_rec[1] = '{rtype: REC_MPRF, tag: mprf_wr_addr,
                      ts: ts_q, data: mprf_wr_data};
        ev_rec[2] = '{rtype: REC_CSR, tag: {2'b0, csr_sel},
                      ts: ts_q, data: csr_data};
    end

    // Pending drop report outranks every hold; otherwise round-robin.
    always_comb begin
        logic [1:0] src;
        grant    = '0;
        drop_gnt = 1'b0;
        push     = 1'b0;
        push_rec = '0;
        rr_d     = rr_q;
        src      = next_src(rr_q);
        if (!full && drop_pend) begin
            drop_gnt = 1'b1;
            push     = 1'b1;
            push_rec = '{rtype: REC_DROP, tag: 5'd0,
                         ts: ts_q, data: {16'h0, drop_cnt}};
        end else if (!full) begin
            for (int k = 0; k < 3; k++) begin
                if (!push && hold_vld[src]) begin
                    push       = 1'b1;
                    grant[src] = 1'b1;
                    push_rec   = hold[src];
                    rr_d       = src;
                end
                src = next_src(src);
            end
        end
    end

    assign drop   = ev & hold_vld & ~grant;
    assign n_drop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            rr_q      <= 2'd2;
            drop_pend <= 1'b0;
            drop_cnt  <= '0;
            ovf_cnt   <= '0;
            hold_vld  <= '0;
            for (int i = 0; i < 3; i++) hold[i] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (start) ts_q <= '0;
            else if (state_q != ST_IDLE) ts_q <= ts_q + 32'd1;
            if (start) begin
                drop_pend <= 1'b0;
                drop_cnt  <= '0;
                ovf_cnt   <= '0;
            end else begin
                if (|drop) ovf_cnt <= sat_add(ovf_cnt, n_drop);
                if (drop_gnt) begin
                    drop_pend <= |drop;
                    drop_cnt  <= {14'b0, n_drop};
                end else if (|drop) begin
                    drop_pend <= 1'b1;
                    drop_cnt  <= sat_add(drop_cnt, n_drop);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (start) begin
                    hold_vld[i] <= 1'b0;
                end else if (ev[i] && (!hold_vld[i] || grant[i])) begin
                    hold_vld[i] <= 1'b1;
                    hold[i]     <= ev_rec[i];
                end else if (grant[i]) begin
                    hold_vld[i] <= 1'b0;
                end
            end
        end
    end

    scr1_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_rec),
        .pop   (rec_vld & rec_rdy),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign rec_vld  = ~empty;
    assign rec_type = head.rtype;
    assign rec_tag  = head.tag;
    assign rec_ts   = head.ts;
    assign rec_data = head.data;

endmodule

// File: tb/tb_scr1_trace_sched.sv
// Scoreboard bench for scr1_trace_sched: directed stimulus pushes
// expected records, a negedge monitor pops and compares them.
module tb_scr1_trace_sched;
    import scr1_trace_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_start, ctrl_stop;
    logic        update_pc_en;
    logic [31:0] update_pc;
    logic        mprf_wr_en;
    logic [4:0]  mprf_wr_addr;
    logic [31:0] mprf_wr_data;
    logic        csr_chg;
    logic [2:0]  csr_sel;
    logic [31:0] csr_data;
    logic        rec_vld, rec_rdy;
    logic [1:0]  rec_type;
    logic [4:0]  rec_tag;
    logic [31:0] rec_ts, rec_data;
    logic        busy;
    logic [15:0] ovf_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t_base = 0;
    int   t0;
    rec_t exp_q [$];

    always #5 clk = ~clk;

    scr1_trace_sched #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_start   (ctrl_start),
        .ctrl_stop    (ctrl_stop),
        .update_pc_en (update_pc_en),
        .update_pc    (update_pc),
        .mprf_wr_en   (mprf_wr_en),
        .mprf_wr_addr (mprf_wr_addr),
        .mprf_wr_data (mprf_wr_data),
        .csr_chg      (csr_chg),
        .csr_sel      (csr_sel),
        .csr_data     (csr_data),
        .rec_vld      (rec_vld),
        .rec_rdy      (rec_rdy),
        .rec_type     (rec_type),
        .rec_tag      (rec_tag),
        .rec_ts       (rec_ts),
        .rec_data     (rec_data),
        .busy         (busy),
        .ovf_cnt      (ovf_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] tsn();
        return 32'(cyc - t_base);
    endfunction

    task automatic push_exp(input rec_type_e t, input logic [4:0] tag,
                            input logic [31:0] ts, input logic [31:0] d);
        rec_t r;
        r = '{rtype: t, tag: tag, ts: ts, data: d};
        exp_q.push_back(r);
    endtask

    task automatic set_ev(input logic pe, input logic [31:0] pc,
                          input logic me, input logic [4:0] ma,
                          input logic [31:0] md, input logic ce,
                          input logic [2:0] cs, input logic [31:0] cd);
        update_pc_en = pe; update_pc = pc;
        mprf_wr_en = me; mprf_wr_addr = ma; mprf_wr_data = md;
        csr_chg = ce; csr_sel = cs; csr_data = cd;
    endtask

    task automatic clr_ev();
        set_ev(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        t_base = cyc;
    endtask

    task automatic wait_empty(input string name, input int n);
        for (int i = 0; i < n && exp_q.size() != 0; i++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (rst_n && rec_vld && rec_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rec: type %0d tag %0d ts %0d data %h, none expected",
                         rec_type, rec_tag, rec_ts, rec_data);
            end else begin
                e = exp_q.pop_front();
                chk("rec_type", 32'(rec_type), 32'(e.rtype));
                chk("rec_tag", 32'(rec_tag), 32'(e.tag));
                chk("rec_ts", rec_ts, e.ts);
                chk("rec_data", rec_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        rec_rdy = 1'b1;
        clr_ev();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(rec_vld), 0);
        chk("rst_type", 32'(rec_type), 0);
        chk("rst_tag", 32'(rec_tag), 0);
        chk("rst_ts", rec_ts, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Three simultaneous sources at ts 7, plus an addr-0 write.
        do_start();
        chk("busy_run", 32'(busy), 1);
        repeat (2) tick();
        set_ev(0, 0, 1, 5'd0, 32'h1234, 0, 0, 0);
        tick();
        clr_ev();
        repeat (4) tick();
        set_ev(1, 32'h1000, 1, 5'd10, 32'hDEAD, 1, 3'd3, 32'h88);
        push_exp(REC_PC, 0, tsn(), 32'h1000);
        push_exp(REC_MPRF, 10, tsn(), 32'hDEAD);
        push_exp(REC_CSR, 3, tsn(), 32'h88);
        chk("ts_seven", tsn(), 7);
        tick();
        clr_ev();
        wait_empty("drain_three", 20);
        chk("ovf_zero_run", 32'(ovf_cnt), 0);

        // Stop, then events while idle produce nothing.
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("stop_idle", 32'(busy), 0);
        set_ev(1, 32'h99, 1, 5'd4, 32'h44, 1, 3'd1, 32'h11);
        tick();
        clr_ev();
        repeat (4) tick();
        chk("idle_no_vld", 32'(rec_vld), 0);
        chk("idle_ovf", 32'(ovf_cnt), 0);

        // Single PC event at ts 5 and its two-cycle latency.
        do_start();
        repeat (5) tick();
        set_ev(1, 32'h200, 0, 0, 0, 0, 0, 0);
        push_exp(REC_PC, 0, 32'd5, 32'h200);
        tick();
        clr_ev();
        chk("lat_n1", 32'(rec_vld), 0);
        tick();
        chk("lat_n2", 32'(rec_vld), 1);
        tick();

        // Back-pressure burst: 4 queued, 1 held, 3 dropped.
        rec_rdy = 1'b0;
        t0 = int'(tsn());
        for (int k = 0; k < 8; k++) begin
            set_ev(1, 32'(32'h300 + k * 4), 0, 0, 0, 0, 0, 0);
            if (k < 4) push_exp(REC_PC, 0, 32'(t0 + k), 32'(32'h300 + k * 4));
            tick();
        end
        clr_ev();
        chk("ovf_burst", 32'(ovf_cnt), 3);
        chk("stall_head", rec_data, 32'h300);
        rec_rdy = 1'b1;
        push_exp(REC_DROP, 0, tsn() + 32'd1, 32'd3);
        push_exp(REC_PC, 0, 32'(t0 + 4), 32'h310);
        wait_empty("drain_burst", 30);

        // Stop with three pending records; ready toggles in drain.
        rec_rdy = 1'b0;
        set_ev(1, 32'h400, 1, 5'd5, 32'h55, 1, 3'd6, 32'h66);
        push_exp(REC_MPRF, 5, tsn(), 32'h55);
        push_exp(REC_CSR, 6, tsn(), 32'h66);
        push_exp(REC_PC, 0, tsn(), 32'h400);
        tick();
        clr_ev();
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        set_ev(1, 32'hBAD, 0, 0, 0, 0, 0, 0);
        tick();
        clr_ev();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            rec_rdy = ~rec_rdy;
            tick();
        end
        chk("drain_stop", 32'(exp_q.size()), 0);
        chk("busy_at_empty", 32'(busy), 1);
        chk("vld_at_empty", 32'(rec_vld), 0);
        tick();
        chk("busy_dropped", 32'(busy), 0);
        chk("ovf_kept", 32'(ovf_cnt), 3);

        // Reset with a non-empty FIFO, then restart from ts 0.
        rec_rdy = 1'b0;
        do_start();
        set_ev(1, 32'h700, 1, 5'd1, 32'h11, 0, 0, 0);
        tick();
        clr_ev();
        repeat (3) tick();
        chk("pre_rst_vld", 32'(rec_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(rec_vld), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ovf", 32'(ovf_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        rec_rdy = 1'b1;
        do_start();
        set_ev(1, 32'h800, 0, 0, 0, 0, 0, 0);
        push_exp(REC_PC, 0, 32'd0, 32'h800);
        tick();
        clr_ev();
        wait_empty("drain_restart", 20);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
